// File: rtl/clock_divider_pkg.sv
// Shared types for the programmable clock divider: FSM states and divisor width.
package clock_divider_pkg;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  typedef logic [CNT_W_DEF-1:0] div_t;
endpackage

// File: rtl/clock_divider_core.sv
// Loadable half-period down-counter driving a registered toggle flop and rise pulse.
module clock_divider_core
  import clock_divider_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             run,
  output logic             clk_out,
  output logic             terminal,
  output logic             rise
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] reload;
  logic             clk_q;
  logic             rise_q;

  assign terminal = (cnt == '0);
  assign clk_out  = clk_q;
  assign rise     = rise_q;

  // A load always restarts a low phase, so a period boundary can never leave a runt pulse.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      reload <= '0;
      clk_q  <= 1'b0;
      rise_q <= 1'b0;
    end else if (load) begin
      cnt    <= load_val;
      reload <= load_val;
      clk_q  <= 1'b0;
      rise_q <= 1'b0;
    end else if (run) begin
      if (terminal) begin
        cnt    <= reload;
        clk_q  <= ~clk_q;
        rise_q <= ~clk_q;
      end else begin
        cnt    <= cnt - 1'b1;
        rise_q <= 1'b0;
      end
    end else begin
      rise_q <= 1'b0;
    end
  end

endmodule

// File: rtl/clock_divider_ctrl.sv
// Command handshake, FSM and pending-command registers around the divider core.
module clock_divider_ctrl
  import clock_divider_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_en,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] active_div
);

  state_t           state, state_nx;
  logic             accept;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             act_load;
  logic             cap_pend;
  logic             pend_en;
  logic [CNT_W-1:0] pend_div;
  logic             terminal;

  assign cfg_ready = (state != PEND);
  assign busy      = (state != IDLE);
  assign accept    = cfg_valid && cfg_ready;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Changes from RUN are parked in PEND until the current period finishes high.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    load_val = '0;
    act_load = 1'b0;
    cap_pend = 1'b0;
    case (state)
      IDLE: begin
        if (accept && cfg_en) begin
          load     = 1'b1;
          load_val = cfg_div;
          act_load = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          cap_pend = 1'b1;
          state_nx = PEND;
        end
      end
      PEND: begin
        if (terminal && clk_out) begin
          load = 1'b1;
          if (pend_en) begin
            load_val = pend_div;
            act_load = 1'b1;
            state_nx = RUN;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      active_div <= CNT_W'(DEFAULT_DIV);
      pend_en    <= 1'b0;
      pend_div   <= '0;
    end else begin
      if (act_load) begin
        active_div <= load_val;
      end
      if (cap_pend) begin
        pend_en  <= cfg_en;
        pend_div <= cfg_div;
      end
    end
  end

  clock_divider_core #(
    .CNT_W(CNT_W)
  ) u_core (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .run      (state != IDLE),
    .clk_out  (clk_out),
    .terminal (terminal),
    .rise     (tick)
  );

endmodule
